// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings, frame constants and tick increment helper for the UART link
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [3:0] {
        TX_IDLE  = 4'd0,
        TX_START = 4'd1,
        TX_B0    = 4'd2,
        TX_B1    = 4'd3,
        TX_B2    = 4'd4,
        TX_B3    = 4'd5,
        TX_B4    = 4'd6,
        TX_B5    = 4'd7,
        TX_B6    = 4'd8,
        TX_B7    = 4'd9,
        TX_STOP  = 4'd10
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // round(rate * 2^acc_width / clk_freq)
    function automatic longint calc_inc(input longint clk_freq, input longint rate, input int acc_width);
        return ((rate << acc_width) + clk_freq / 2) / clk_freq;
    endfunction

endpackage

// File: rtl/uart_async_link_if.sv
// rtl/uart_async_link_if.sv - byte-side and serial-pin signals of the UART link
interface uart_async_link_if;
    logic       TxD_start;
    logic [7:0] TxD_data;
    logic       TxD;
    logic       TxD_busy;
    logic       BitTick;
    logic       RxD;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;
    logic       RxD_idle;
    logic       RxD_endofpacket;
    logic       OversamplingTick;

    modport master (
        output TxD_start, TxD_data, RxD,
        input  TxD, TxD_busy, BitTick, RxD_data_ready, RxD_data,
               RxD_idle, RxD_endofpacket, OversamplingTick
    );

    modport slave (
        input  TxD_start, TxD_data, RxD,
        output TxD, TxD_busy, BitTick, RxD_data_ready, RxD_data,
               RxD_idle, RxD_endofpacket, OversamplingTick
    );
endinterface

// File: rtl/uart_baud_tick_gen.sv
// rtl/uart_baud_tick_gen.sv - phase-accumulator tick generator; tick is the accumulator carry
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 125000000,
    parameter int Rate         = 115200,
    parameter int AccWidth     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam longint INC_L = calc_inc(ClkFrequency, Rate, AccWidth);
    localparam logic [AccWidth:0] INC = INC_L[AccWidth:0];

    logic [AccWidth:0] acc;

    // Holding the accumulator at zero while disabled restarts the phase at every frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (!enable)
            acc <= '0;
        else
            acc <= {1'b0, acc[AccWidth-1:0]} + INC;
    end

    assign tick = acc[AccWidth];

endmodule

// File: rtl/uart_async_link.sv
// rtl/uart_async_link.sv - 8N1 UART transmitter and oversampled receiver; UART_RX_GLITCH_FILTER_EN adds an RX majority filter
module uart_async_link
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 125000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8,
    parameter int AccWidth     = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_async_link_if.slave  bus
);

    localparam int CW = $clog2(Oversampling);
    localparam int GW = $clog2(2 * Oversampling) + 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(Oversampling / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(Oversampling - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(2 * Oversampling);

    tx_state_t  tx_state, tx_next;
    logic [7:0] tx_shift;
    logic [2:0] tx_idx;
    logic       tx_bit;
    logic       tx_busy;
    logic       bit_tick;

    assign tx_busy = (tx_state != TX_IDLE);

    uart_baud_tick_gen #(.ClkFrequency(ClkFrequency), .Rate(Baud), .AccWidth(AccWidth)) u_tx_tick (
        .clk(clk), .rst(rst), .enable(tx_busy), .tick(bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_IDLE && bus.TxD_start)
                tx_shift <= bus.TxD_data;
        end
    end

    always_comb begin
        tx_next = tx_state;
        tx_bit  = 1'b1;
        tx_idx  = 3'(4'(tx_state) - 4'(TX_B0));
        case (tx_state)
            TX_IDLE:  if (bus.TxD_start) tx_next = TX_START;
            TX_START: begin
                tx_bit = 1'b0;
                if (bit_tick) tx_next = TX_B0;
            end
            TX_STOP:  if (bit_tick) tx_next = TX_IDLE;
            default: begin
                tx_bit = tx_shift[tx_idx];
                if (bit_tick) tx_next = tx_state_t'(4'(tx_state) + 4'd1);
            end
        endcase
    end

    assign bus.TxD      = tx_bit;
    assign bus.TxD_busy = tx_busy;
    assign bus.BitTick  = bit_tick;

    logic os_tick;
    logic [1:0] rx_sync;
    logic rx_line;

    uart_baud_tick_gen #(.ClkFrequency(ClkFrequency), .Rate(Baud * Oversampling), .AccWidth(AccWidth)) u_rx_tick (
        .clk(clk), .rst(rst), .enable(1'b1), .tick(os_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], bus.RxD};
    end

`ifdef UART_RX_GLITCH_FILTER_EN
    logic [2:0] rx_hist;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rx_hist <= 3'b111;
        else if (os_tick) rx_hist <= {rx_hist[1:0], rx_sync[1]};
    end
    assign rx_line = (rx_hist[0] & rx_hist[1]) | (rx_hist[1] & rx_hist[2]) | (rx_hist[0] & rx_hist[2]);
`else
    assign rx_line = rx_sync[1];
`endif

    rx_state_t  rx_state, rx_next;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0] rx_bit, rx_bit_n;
    logic [7:0] rx_shift, rx_shift_n, rx_data, rx_data_n;
    logic       rx_ready, rx_ready_n;
    logic [GW-1:0] gap;
    logic       rx_idle, idle_q, rx_got, rx_eop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_ready <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_data  <= rx_data_n;
            rx_ready <= rx_ready_n;
        end
    end

    // rx_cnt wraps to zero on CNT_LAST, so DATA and STOP sample one bit period apart
    always_comb begin
        rx_next    = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data;
        rx_ready_n = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (!rx_line) rx_next = RX_START;
            end
            RX_START: if (os_tick) begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == CNT_MID) begin
                    rx_cnt_n = '0;
                    rx_bit_n = '0;
                    rx_next  = rx_line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: if (os_tick) begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == CNT_LAST) begin
                    rx_shift_n = {rx_line, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'(DATA_BITS - 1)) rx_next = RX_STOP;
                end
            end
            RX_STOP: if (os_tick) begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == CNT_LAST) begin
                    rx_next = RX_IDLE;
                    if (rx_line) begin
                        rx_data_n  = rx_shift;
                        rx_ready_n = 1'b1;
                    end
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    assign rx_idle = (gap == GAP_MAX);
    assign rx_eop  = rx_idle & ~idle_q & rx_got;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap    <= GAP_MAX;
            idle_q <= 1'b1;
            rx_got <= 1'b0;
        end else begin
            idle_q <= rx_idle;
            if (rx_state == RX_IDLE && !rx_line)
                gap <= '0;
            else if (rx_state == RX_IDLE && os_tick && gap != GAP_MAX)
                gap <= gap + 1'b1;
            if (rx_ready)    rx_got <= 1'b1;
            else if (rx_eop) rx_got <= 1'b0;
        end
    end

    assign bus.RxD_data_ready   = rx_ready;
    assign bus.RxD_data         = rx_data;
    assign bus.RxD_idle         = rx_idle;
    assign bus.RxD_endofpacket  = rx_eop;
    assign bus.OversamplingTick = os_tick;

endmodule

// File: tb/tb_uart_async_link.sv
// tb/tb_uart_async_link.sv - directed loopback, timing, guard, framing, idle and reset checks for uart_async_link
module tb_uart_async_link;

    localparam int CLK_HZ   = 1_000_000;
    localparam int BAUD     = 15_000;
    localparam int OS       = 8;
    localparam int BIT_CLKS = 67;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loop_en = 1'b0;
    logic rxd_drv = 1'b1;

    always #5 clk = ~clk;

    uart_async_link_if bus();
    assign bus.RxD = loop_en ? bus.TxD : rxd_drv;

    uart_async_link #(.ClkFrequency(CLK_HZ), .Baud(BAUD), .Oversampling(OS), .AccWidth(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_q[$];
    int tick_cnt = 0;
    int eop_cnt  = 0;
    int os_cnt   = 0;

    always @(negedge clk) begin
        if (bus.RxD_data_ready === 1'b1) rx_q.push_back(bus.RxD_data);
        if (bus.BitTick === 1'b1) tick_cnt++;
        if (bus.RxD_endofpacket === 1'b1) eop_cnt++;
        if (bus.OversamplingTick === 1'b1) os_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (bus.TxD_busy !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) check("send_wait", bus.TxD_busy, 0);
        bus.TxD_data  = b;
        bus.TxD_start = 1'b1;
        @(negedge clk);
        bus.TxD_start = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin @(negedge clk); t++; end
        if (rx_q.size() < n) check(tag, rx_q.size(), n);
    endtask

    task automatic drive_frame(input logic [7:0] b, input int stop_low_clks);
        rxd_drv = 1'b0;
        tick(BIT_CLKS);
        for (int k = 0; k < 8; k++) begin
            rxd_drv = b[k];
            tick(BIT_CLKS);
        end
        rxd_drv = 1'b0;
        tick(stop_low_clks);
        rxd_drv = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int base_q, base_t, base_e, dur, t;
        logic [9:0] txbits;
        logic [9:0] exp_bits;

        bus.TxD_start = 1'b0;
        bus.TxD_data  = 8'h00;
        rst = 1'b1;
        tick(3);
        check("rst_txd", bus.TxD, 1);
        check("rst_busy", bus.TxD_busy, 0);
        check("rst_bittick", bus.BitTick, 0);
        check("rst_rxdata", bus.RxD_data, 8'h00);
        check("rst_ready", bus.RxD_data_ready, 0);
        check("rst_idle", bus.RxD_idle, 1);
        check("rst_eop", bus.RxD_endofpacket, 0);
        rst = 1'b0;
        tick(20);

        // Oversampling tick rate: 1000 clks / 8.334 clks per tick
        base_t = os_cnt;
        tick(1000);
        check("os_rate", (os_cnt - base_t >= 119) && (os_cnt - base_t <= 121), 1);

        // Frame timing on 0xA5: start, 1,0,1,0,0,1,0,1, stop
        loop_en  = 1'b1;
        exp_bits = 10'h34A;
        txbits   = '0;
        base_q = rx_q.size();
        base_t = tick_cnt;
        send_byte(8'hA5);
        dur = 0;
        while (bus.TxD_busy === 1'b1 && dur < 2000) begin
            for (int k = 0; k < 10; k++)
                if (dur == 34 + (k * 667) / 10) txbits[k] = bus.TxD;
            @(negedge clk);
            dur++;
        end
        for (int k = 0; k < 10; k++) check($sformatf("tx_bit%0d", k), txbits[k], exp_bits[k]);
        check("busy_len_1pct", (dur >= 660) && (dur <= 673), 1);
        check("bittick_count", tick_cnt - base_t, 10);
        check("tx_idle_high", bus.TxD, 1);
        wait_rx(base_q + 1, 400, "a5_rx_wait");
        if (rx_q.size() > base_q) check("a5_rx", rx_q[base_q], 8'hA5);

        // Back-to-back loopback 0x01..0x10
        tick(200);
        base_q = rx_q.size();
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        wait_rx(base_q + 16, 2000, "loop_rx_wait");
        check("loop_count", rx_q.size() - base_q, 16);
        for (int i = 1; i <= 16; i++)
            if (rx_q.size() >= base_q + i) check($sformatf("loop_byte%0d", i), rx_q[base_q+i-1], i);

        // Busy guard: second request mid-frame is dropped
        tick(300);
        base_q = rx_q.size();
        send_byte(8'h3C);
        tick(200);
        bus.TxD_data  = 8'hFF;
        bus.TxD_start = 1'b1;
        tick(1);
        bus.TxD_start = 1'b0;
        check("guard_busy", bus.TxD_busy, 1);
        tick(1600);
        check("guard_no_second", bus.TxD_busy, 0);
        check("guard_count", rx_q.size() - base_q, 1);
        if (rx_q.size() > base_q) check("guard_byte", rx_q[base_q], 8'h3C);

        // Framing error: 0x55 with a low stop bit
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        tick(200);
        base_q = rx_q.size();
        drive_frame(8'h55, 40);
        tick(400);
        check("ferr_no_ready", rx_q.size() - base_q, 0);
        check("ferr_data_kept", bus.RxD_data, 8'h3C);

        // Glitch shorter than the start half-bit, then idle / end-of-packet
        t = 0;
        while (bus.RxD_idle !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        check("pre_glitch_idle", bus.RxD_idle, 1);
        base_q = rx_q.size();
        base_e = eop_cnt;
        rxd_drv = 1'b0;
        tick(17);
        rxd_drv = 1'b1;
        tick(300);
        check("glitch_no_ready", rx_q.size() - base_q, 0);
        check("glitch_no_eop", eop_cnt - base_e, 0);
        loop_en = 1'b1;
        send_byte(8'h96);
        wait_rx(base_q + 1, 1200, "idle_rx_wait");
        if (rx_q.size() > base_q) check("idle_byte", rx_q[base_q], 8'h96);
        base_e = eop_cnt;
        check("idle_low_after_frame", bus.RxD_idle, 0);
        tick(250);
        check("idle_high", bus.RxD_idle, 1);
        check("eop_once", eop_cnt - base_e, 1);

        // Reset during B3 of 0x81
        base_q = rx_q.size();
        send_byte(8'h81);
        base_t = tick_cnt;
        t = 0;
        while (tick_cnt - base_t < 4 && t < 1000) begin @(negedge clk); t++; end
        check("reach_b3", tick_cnt - base_t, 4);
        tick(30);
        check("b3_bit", bus.TxD, 0);
        rst = 1'b1;
        #1;
        check("midrst_txd", bus.TxD, 1);
        check("midrst_busy", bus.TxD_busy, 0);
        tick(3);
        rst = 1'b0;
        tick(1500);
        check("midrst_no_ready", rx_q.size() - base_q, 0);
        send_byte(8'h42);
        wait_rx(base_q + 1, 1200, "post_rst_rx_wait");
        check("post_rst_count", rx_q.size() - base_q, 1);
        if (rx_q.size() > base_q) check("post_rst_byte", rx_q[base_q], 8'h42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
